// File: rtl/adc_dec_pkg.sv
// Shared types and default widths for the two-channel AXI-Stream ADC decimator.
package adc_dec_pkg;

  localparam int unsigned AxisTdataWidthDef = 32;
  localparam int unsigned CntrWidthDef      = 16;
  localparam int unsigned OverrunCntWidth   = 16;

  typedef enum logic [0:0] {
    StIdle,
    StAccum
  } dec_state_e;

endpackage

// File: rtl/adc_dec_acc.sv
// One channel of the decimator: wrapping accumulator plus the held result word.
module adc_dec_acc #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             sample_i,
  input  logic             last_i,
  input  logic             load_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] result_o
);

  logic [Width-1:0] acc_q, acc_d;
  logic [Width-1:0] res_q, res_d;
  logic [Width-1:0] sum;

  // Two's complement add, wrapping modulo 2^Width.
  assign sum = acc_q + data_i;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (sample_i) begin
      acc_d = last_i ? '0 : sum;
    end
  end

  always_comb begin
    res_d = res_q;
    if (load_i) begin
      res_d = sum;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      res_q <= '0;
    end else begin
      acc_q <= acc_d;
      res_q <= res_d;
    end
  end

  assign result_o = res_q;

endmodule

// File: rtl/axis_adc_2ch_decimator.sv
// Two-channel sum-and-dump decimator with a one-word output holding register.
// Optional: define ADC_DEC_OVERRUN_CNT_EN to add the saturating sts_overrun_cnt output.
module axis_adc_2ch_decimator
  import adc_dec_pkg::*;
#(
  parameter int unsigned AXIS_TDATA_WIDTH = AxisTdataWidthDef,
  parameter int unsigned CNTR_WIDTH       = CntrWidthDef
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          run,
  input  logic [CNTR_WIDTH-1:0]         cfg_ratio,
  input  logic                          s0_axis_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0]   s0_axis_tdata,
  input  logic                          s1_axis_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0]   s1_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [2*AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
`ifdef ADC_DEC_OVERRUN_CNT_EN
  output logic [OverrunCntWidth-1:0]    sts_overrun_cnt,
`endif
  output logic                          sts_overrun
);

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  dec_state_e            state_q;
  logic [CNTR_WIDTH-1:0] cnt_q;
  logic [CNTR_WIDTH-1:0] ratio_q;
  logic [CNTR_WIDTH-1:0] n_eff;
  logic                  sample;
  logic                  last;
  logic                  acc_clr;
  logic                  load;
  logic                  drop;
  logic                  tvalid_q;
  logic                  overrun_q;

  assign n_eff   = (ratio_q == '0) ? CNTR_WIDTH'(1) : ratio_q;
  assign sample  = (state_q == StAccum) && run && s0_axis_tvalid && s1_axis_tvalid;
  assign last    = sample && (cnt_q == n_eff - CNTR_WIDTH'(1));
  assign acc_clr = (state_q != StAccum) || !run;
  assign load    = last && (!tvalid_q || m_axis_tready);
  assign drop    = last && tvalid_q && !m_axis_tready;

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ratio_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (run) begin
            state_q <= StAccum;
            ratio_q <= cfg_ratio;
          end
        end
        StAccum: begin
          if (!run) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (last) begin
            cnt_q   <= '0;
            ratio_q <= cfg_ratio;
          end else if (sample) begin
            cnt_q <= cnt_q + CNTR_WIDTH'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // A pending word survives run going low; only acceptance or reset clears it.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      tvalid_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (load) begin
        tvalid_q <= 1'b1;
      end else if (m_axis_tready) begin
        tvalid_q <= 1'b0;
      end
      if (drop) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign sts_overrun   = overrun_q;

`ifdef ADC_DEC_OVERRUN_CNT_EN
  logic [OverrunCntWidth-1:0] ovr_cnt_q;

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_cnt_q <= '0;
    end else if (drop && (ovr_cnt_q != '1)) begin
      ovr_cnt_q <= ovr_cnt_q + OverrunCntWidth'(1);
    end
  end

  assign sts_overrun_cnt = ovr_cnt_q;
`endif

  logic [AXIS_TDATA_WIDTH-1:0] res_a;
  logic [AXIS_TDATA_WIDTH-1:0] res_b;

  adc_dec_acc #(
    .Width(AXIS_TDATA_WIDTH)
  ) u_acc_a (
    .clk_i   (aclk),
    .rst_ni  (rst_n),
    .clr_i   (acc_clr),
    .sample_i(sample),
    .last_i  (last),
    .load_i  (load),
    .data_i  (s0_axis_tdata),
    .result_o(res_a)
  );

  adc_dec_acc #(
    .Width(AXIS_TDATA_WIDTH)
  ) u_acc_b (
    .clk_i   (aclk),
    .rst_ni  (rst_n),
    .clr_i   (acc_clr),
    .sample_i(sample),
    .last_i  (last),
    .load_i  (load),
    .data_i  (s1_axis_tdata),
    .result_o(res_b)
  );

  assign m_axis_tdata = {res_b, res_a};

endmodule

// File: tb/tb_axis_adc_2ch_decimator.sv
// Self-checking bench for axis_adc_2ch_decimator: directed scenarios plus a random run
// against an arithmetic reference model.
module tb_axis_adc_2ch_decimator;

  localparam int W  = 32;
  localparam int CW = 16;

  logic          aclk;
  logic          aresetn;
  logic          run;
  logic [CW-1:0] cfg_ratio;
  logic          s0_axis_tvalid;
  logic [W-1:0]  s0_axis_tdata;
  logic          s1_axis_tvalid;
  logic [W-1:0]  s1_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [2*W-1:0] m_axis_tdata;
  logic          sts_overrun;
`ifdef ADC_DEC_OVERRUN_CNT_EN
  logic [15:0]   sts_overrun_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit           m_active;
  int           m_n;
  int           m_cnt;
  logic [W-1:0] m_sa, m_sb;
  bit           m_ov;
  logic [2*W-1:0] m_od;
  bit           m_ovr;
  int           m_ovrcnt;

  axis_adc_2ch_decimator dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .run            (run),
    .cfg_ratio      (cfg_ratio),
    .s0_axis_tvalid (s0_axis_tvalid),
    .s0_axis_tdata  (s0_axis_tdata),
    .s1_axis_tvalid (s1_axis_tvalid),
    .s1_axis_tdata  (s1_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
`ifdef ADC_DEC_OVERRUN_CNT_EN
    .sts_overrun_cnt(sts_overrun_cnt),
`endif
    .sts_overrun    (sts_overrun)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic model_reset();
    m_active = 0; m_n = 1; m_cnt = 0; m_sa = '0; m_sb = '0;
    m_ov = 0; m_od = '0; m_ovr = 0; m_ovrcnt = 0;
  endtask

  // Applies the decimation rules to the inputs present at this clock edge.
  task automatic model_edge();
    bit           res;
    logic [2*W-1:0] rd;
    res = 0;
    rd  = '0;
    if (!m_active) begin
      if (run) begin
        m_active = 1; m_cnt = 0; m_sa = '0; m_sb = '0;
        m_n = (cfg_ratio < 2) ? 1 : int'(cfg_ratio);
      end
    end else if (!run) begin
      m_active = 0;
    end else if (s0_axis_tvalid && s1_axis_tvalid) begin
      m_sa = m_sa + s0_axis_tdata;
      m_sb = m_sb + s1_axis_tdata;
      m_cnt++;
      if (m_cnt == m_n) begin
        res = 1; rd = {m_sb, m_sa};
        m_sa = '0; m_sb = '0; m_cnt = 0;
        m_n = (cfg_ratio < 2) ? 1 : int'(cfg_ratio);
      end
    end
    if (res) begin
      if (!m_ov || m_axis_tready) begin
        m_ov = 1; m_od = rd;
      end else begin
        m_ovr = 1;
        if (m_ovrcnt < 65535) m_ovrcnt++;
      end
    end else if (m_axis_tready) begin
      m_ov = 0;
    end
  endtask

  task automatic step(input logic r, input logic v0, input logic [W-1:0] a,
                      input logic v1, input logic [W-1:0] b, input logic rdy);
    run = r;
    s0_axis_tvalid = v0; s0_axis_tdata = a;
    s1_axis_tvalid = v1; s1_axis_tdata = b;
    m_axis_tready = rdy;
    @(posedge aclk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    run = 1'b0; s0_axis_tvalid = 1'b0; s1_axis_tvalid = 1'b0;
    s0_axis_tdata = '0; s1_axis_tdata = '0; m_axis_tready = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    model_reset();
    repeat (3) step(0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || sts_overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got v=%b d=%h o=%b want 0/0/0", m_axis_tvalid, m_axis_tdata,
               sts_overrun);
    end
    cfg_ratio = 1;
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 9, 1, 9, 0);
    step(1, 1, 9, 1, 9, 0);
    checks++;
    if (m_axis_tvalid !== 1'b1 || sts_overrun !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_activity got v=%b o=%b want 1/1", m_axis_tvalid, sts_overrun);
    end
    aresetn = 1'b0;
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || sts_overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_async got v=%b d=%h o=%b want 0/0/0", m_axis_tvalid, m_axis_tdata,
               sts_overrun);
    end
    do_reset();
    checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0) begin
      errors++;
      $display("FAIL reset_release got v=%b d=%h want 0/0", m_axis_tvalid, m_axis_tdata);
    end
  endtask

  task automatic test_basic_n4();
    logic [W-1:0] a_vals [4];
    a_vals = '{32'd1, 32'd2, 32'd3, 32'd4};
    do_reset();
    cfg_ratio = 4;
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, a_vals[i], 1, 32'hFFFF_FFFF, 1);
      if (i < 3) begin
        checks++;
        if (m_axis_tvalid !== 1'b0) begin
          errors++;
          $display("FAIL n4_early_valid sample=%0d got %b want 0", i, m_axis_tvalid);
        end
      end
    end
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 64'hFFFF_FFFC_0000_000A) begin
      errors++;
      $display("FAIL n4_word got v=%b d=%h want 1/fffffffc0000000a", m_axis_tvalid, m_axis_tdata);
    end
    step(1, 0, 0, 0, 0, 1);
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL n4_accept got %b want 0", m_axis_tvalid);
    end
  endtask

  task automatic test_n1();
    do_reset();
    cfg_ratio = 0;
    step(1, 0, 0, 0, 0, 1);
    step(1, 1, 5, 1, 0, 1);
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 64'd5) begin
      errors++;
      $display("FAIL n1_first got v=%b d=%h want 1/5", m_axis_tvalid, m_axis_tdata);
    end
    step(1, 1, 7, 1, 0, 1);
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 64'd7) begin
      errors++;
      $display("FAIL n1_second got v=%b d=%h want 1/7", m_axis_tvalid, m_axis_tdata);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    cfg_ratio = 2;
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 1, W'(i + 1), 1, W'(10 * (i + 1)), 0);
      if (i == 1) begin
        checks++;
        if (sts_overrun !== 1'b0 || m_axis_tvalid !== 1'b1) begin
          errors++;
          $display("FAIL ovr_first got o=%b v=%b want 0/1", sts_overrun, m_axis_tvalid);
        end
      end
    end
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== {32'd30, 32'd3} || sts_overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_held got v=%b d=%h o=%b want 1/0000001e00000003/1", m_axis_tvalid,
               m_axis_tdata, sts_overrun);
    end
`ifdef ADC_DEC_OVERRUN_CNT_EN
    checks++;
    if (sts_overrun_cnt !== 16'd4) begin
      errors++;
      $display("FAIL ovr_cnt got %0d want 4", sts_overrun_cnt);
    end
`endif
    step(0, 0, 0, 0, 0, 1);
    checks++;
    if (m_axis_tvalid !== 1'b0 || sts_overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_sticky got v=%b o=%b want 0/1", m_axis_tvalid, sts_overrun);
    end
  endtask

  task automatic test_run_drop();
    bit seen;
    do_reset();
    cfg_ratio = 8;
    seen = 0;
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 1, 100, 1, 100, 1);
    step(0, 0, 0, 0, 0, 1);
    if (m_axis_tvalid) seen = 1;
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      step(1, 1, W'(i + 1), 1, -W'(i + 1), 1);
      if (i < 7 && m_axis_tvalid) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rundrop_early got early word want none");
    end
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 64'hFFFF_FFDC_0000_0024) begin
      errors++;
      $display("FAIL rundrop_word got v=%b d=%h want 1/ffffffdc00000024", m_axis_tvalid,
               m_axis_tdata);
    end
  endtask

  task automatic test_valid_gap();
    do_reset();
    cfg_ratio = 4;
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, W'(10 * (i + 1)), (i != 1), W'(i + 1), 1);
      if (i == 3) begin
        checks++;
        if (m_axis_tvalid !== 1'b0) begin
          errors++;
          $display("FAIL gap_early got %b want 0", m_axis_tvalid);
        end
      end
    end
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== {32'd13, 32'd130}) begin
      errors++;
      $display("FAIL gap_word got v=%b d=%h want 1/0000000d00000082", m_axis_tvalid, m_axis_tdata);
    end
  endtask

  task automatic test_ratio_change();
    do_reset();
    cfg_ratio = 4;
    step(1, 0, 0, 0, 0, 1);
    step(1, 1, 1, 1, 0, 1);
    cfg_ratio = 2;
    for (int i = 2; i <= 4; i++) begin
      step(1, 1, W'(i), 1, 0, 1);
      if (i == 2) begin
        checks++;
        if (m_axis_tvalid !== 1'b0) begin
          errors++;
          $display("FAIL ratio_early got %b want 0", m_axis_tvalid);
        end
      end
    end
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 64'd10) begin
      errors++;
      $display("FAIL ratio_first got v=%b d=%h want 1/a", m_axis_tvalid, m_axis_tdata);
    end
    step(1, 1, 5, 1, 0, 1);
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL ratio_mid got %b want 0", m_axis_tvalid);
    end
    step(1, 1, 6, 1, 0, 1);
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 64'd11) begin
      errors++;
      $display("FAIL ratio_second got v=%b d=%h want 1/b", m_axis_tvalid, m_axis_tdata);
    end
  endtask

  task automatic test_random();
    int bad;
    do_reset();
    bad = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 63) == 0) cfg_ratio = CW'($urandom_range(0, 5));
      step(($urandom_range(0, 31) != 0), ($urandom_range(0, 9) < 8), $urandom(),
           ($urandom_range(0, 9) < 8), $urandom(), ($urandom_range(0, 9) < 6));
      checks++;
      if (m_axis_tvalid !== m_ov || m_axis_tdata !== m_od || sts_overrun !== m_ovr) begin
        errors++;
        if (bad < 10) begin
          $display("FAIL rand_cycle=%0d got v=%b d=%h o=%b want v=%b d=%h o=%b", c,
                   m_axis_tvalid, m_axis_tdata, sts_overrun, m_ov, m_od, m_ovr);
        end
        bad++;
      end
`ifdef ADC_DEC_OVERRUN_CNT_EN
      checks++;
      if (int'(sts_overrun_cnt) != m_ovrcnt) begin
        errors++;
        if (bad < 10) begin
          $display("FAIL rand_ovrcnt cycle=%0d got %0d want %0d", c, sts_overrun_cnt, m_ovrcnt);
        end
        bad++;
      end
`endif
    end
  endtask

  initial begin
    aresetn = 1'b0;
    cfg_ratio = '0;
    model_reset();
    test_reset();
    test_basic_n4();
    test_n1();
    test_overrun();
    test_run_drop();
    test_valid_gap();
    test_ratio_change();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
